if_fetch_unit: RTL

Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC, issues single-outstanding reads to instruction memory, and predicts the next PC with a direct-mapped BTB holding 2-bit counters. Presents pc_IF, branch_predicted_pc_IF and instruction_IF to IF/ID. Accepts stall from hazard logic and redirect (flush plus correct PC) from EX.

---
 rtl/if_fetch_unit.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch stage with a single-outstanding memory port
//                and a direct-mapped BTB with 2-bit counters
//                (BTB present when FETCH_BTB_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter int                   WORD_SIZE  = 16,
    parameter int                   BTB_IDX_W  = 3,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
    parameter logic [3:0]           OPCODE_NOP = 4'hF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] correct_pc,
    input  logic                 update_en,
    input  logic [WORD_SIZE-1:0] update_pc,
    input  logic [WORD_SIZE-1:0] update_target,
    input  logic                 update_taken,
    output logic                 i_readM,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic                 i_ready,
    input  logic [WORD_SIZE-1:0] i_data,
    output logic [WORD_SIZE-1:0] pc_IF,
    output logic [WORD_SIZE-1:0] branch_predicted_pc_IF,
    output logic [WORD_SIZE-1:0] instruction_IF,
    output logic                 instr_valid_IF
);

    localparam logic [WORD_SIZE-1:0] c_NOP = {OPCODE_NOP, {(WORD_SIZE-4){1'b0}}};
    localparam logic [WORD_SIZE-1:0] c_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_ST_FETCH = 2'd0;
    localparam logic [1:0] c_ST_PEND  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 r_active;
    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] r_req_addr;
    logic                 r_outstanding;
    logic [WORD_SIZE-1:0] r_slot_pc;
    logic [WORD_SIZE-1:0] r_slot_pred;
    logic [WORD_SIZE-1:0] r_slot_instr;
    logic                 r_slot_valid;
    logic [WORD_SIZE-1:0] r_pend_pc;
    logic [WORD_SIZE-1:0] r_pend_pred;
    logic [WORD_SIZE-1:0] r_pend_instr;
    logic [WORD_SIZE-1:0] w_pred;

    logic w_issue;
    logic w_resp;
    logic w_slot_free;

    assign w_issue     = r_active && (r_state == c_ST_FETCH) && !r_outstanding;
    assign w_resp      = i_ready && r_outstanding;
    assign w_slot_free = !r_slot_valid || !stall;

    // Request line is held as a level until the response pulse.
    assign i_readM   = r_active && ((r_state == c_ST_FETCH) || (r_state == c_ST_DRAIN));
    assign i_address = r_outstanding ? r_req_addr : r_pc;

    assign pc_IF                  = r_slot_pc;
    assign branch_predicted_pc_IF = r_slot_pred;
    assign instruction_IF         = r_slot_instr;
    assign instr_valid_IF         = r_slot_valid;

`ifdef FETCH_BTB_EN
    localparam int c_ENTRIES = 2 ** BTB_IDX_W;
    localparam int c_TAG_W   = WORD_SIZE - BTB_IDX_W;

    logic [c_ENTRIES-1:0] r_btb_valid;
    logic [1:0]           r_btb_ctr    [c_ENTRIES];
    logic [c_TAG_W-1:0]   r_btb_tag    [c_ENTRIES];
    logic [WORD_SIZE-1:0] r_btb_target [c_ENTRIES];

    logic [BTB_IDX_W-1:0] w_lk_idx;
    logic [BTB_IDX_W-1:0] w_up_idx;
    logic [c_TAG_W-1:0]   w_up_tag;
    logic                 w_lk_hit;
    logic                 w_up_hit;

    assign w_lk_idx = r_pc[BTB_IDX_W-1:0];
    assign w_up_idx = update_pc[BTB_IDX_W-1:0];
    assign w_up_tag = update_pc[WORD_SIZE-1:BTB_IDX_W];
    assign w_lk_hit = r_btb_valid[w_lk_idx] && r_btb_ctr[w_lk_idx][1]
                   && (r_btb_tag[w_lk_idx] == r_pc[WORD_SIZE-1:BTB_IDX_W]);
    assign w_up_hit = r_btb_valid[w_up_idx] && (r_btb_tag[w_up_idx] == w_up_tag);
    assign w_pred   = w_lk_hit ? r_btb_target[w_lk_idx] : r_pc + c_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btb_valid <= '0;
            for (int i = 0; i < c_ENTRIES; i++) r_btb_ctr[i] <= 2'd0;
        end else if (update_en) begin
            if (w_up_hit) begin
                if (update_taken) begin
                    if (r_btb_ctr[w_up_idx] != 2'd3) r_btb_ctr[w_up_idx] <= r_btb_ctr[w_up_idx] + 2'd1;
                end else if (r_btb_ctr[w_up_idx] != 2'd0) begin
                    r_btb_ctr[w_up_idx] <= r_btb_ctr[w_up_idx] - 2'd1;
                end
            end else if (update_taken) begin
                r_btb_valid[w_up_idx] <= 1'b1;
                r_btb_ctr[w_up_idx]   <= 2'd2;
            end
        end
    end

    // Tag is rewritten on a hit too; it is unchanged in that case.
    always_ff @(posedge clk) begin
        if (update_en && update_taken) begin
            r_btb_tag[w_up_idx]    <= w_up_tag;
            r_btb_target[w_up_idx] <= update_target;
        end
    end
`else
    logic w_unused_update;
    assign w_unused_update = ^{update_en, update_pc, update_target, update_taken};
    assign w_pred          = r_pc + c_ONE;
`endif

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ((r_outstanding || w_issue) && !w_resp) ? c_ST_DRAIN : c_ST_FETCH;
        end else begin
            case (r_state)
                c_ST_FETCH: if (w_resp && !w_slot_free) w_state_next = c_ST_PEND;
                c_ST_PEND:  if (!stall) w_state_next = c_ST_FETCH;
                c_ST_DRAIN: if (w_resp) w_state_next = c_ST_FETCH;
                default:    w_state_next = c_ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_ST_FETCH;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_active <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_req_addr    <= '0;
            r_outstanding <= 1'b0;
            r_slot_pc     <= '0;
            r_slot_pred   <= '0;
            r_slot_instr  <= c_NOP;
            r_slot_valid  <= 1'b0;
            r_pend_pc     <= '0;
            r_pend_pred   <= '0;
            r_pend_instr  <= '0;
        end else begin
            // A request issued in a flush cycle is still tracked so DRAIN can retire it.
            if (w_resp) begin
                r_outstanding <= 1'b0;
            end else if (w_issue) begin
                r_outstanding <= 1'b1;
                r_req_addr    <= r_pc;
            end

            if (flush) begin
                r_pc         <= correct_pc;
                r_slot_valid <= 1'b0;
                r_slot_instr <= c_NOP;
            end else if ((r_state == c_ST_FETCH) && w_resp) begin
                r_pc <= w_pred;
                if (w_slot_free) begin
                    r_slot_pc    <= r_pc;
                    r_slot_pred  <= w_pred;
                    r_slot_instr <= i_data;
                    r_slot_valid <= 1'b1;
                end else begin
                    r_pend_pc    <= r_pc;
                    r_pend_pred  <= w_pred;
                    r_pend_instr <= i_data;
                end
            end else if ((r_state == c_ST_PEND) && !stall) begin
                r_slot_pc    <= r_pend_pc;
                r_slot_pred  <= r_pend_pred;
                r_slot_instr <= r_pend_instr;
                r_slot_valid <= 1'b1;
            end else if (!stall) begin
                r_slot_valid <= 1'b0;
                r_slot_instr <= c_NOP;
            end
        end
    end

endmodule
`default_nettype wire
